// File: rtl/vc_switch_ctrl_hyst_if.sv
// rtl/vc_switch_ctrl_hyst_if.sv - control-voltage sample stream into the switch controller
interface vc_switch_ctrl_hyst_if #(
  parameter int W = 12
) ();
  logic                vc_valid;
  logic signed [W-1:0] vc_data;
  logic                vc_ready;

  modport master (output vc_valid, output vc_data, input vc_ready);
  modport slave  (input vc_valid, input vc_data, output vc_ready);
endinterface

// File: rtl/vc_switch_ctrl_hyst.sv
// rtl/vc_switch_ctrl_hyst.sv - debounced hysteresis comparator driving a voltage-controlled switch
module vc_switch_ctrl_hyst #(
  parameter int                  W   = 12,
  parameter logic signed [W-1:0] VT  = '0,
  parameter int                  VH  = 1,
  parameter int                  DEB = 3,
  parameter int                  CW  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  vc_switch_ctrl_hyst_if.slave       vc,
  output logic                       sw_on,
  output logic                       sw_toggle,
  output logic [CW-1:0]              deb_cnt
);

  typedef enum logic [1:0] {S_OFF, S_ARM_ON, S_ON, S_ARM_OFF} state_t;

  // One extra bit keeps VT +/- VH from wrapping at the ends of the sample range.
  localparam logic signed [W:0] HI = $signed({VT[W-1], VT}) + $signed((W+1)'(VH));
  localparam logic signed [W:0] LO = $signed({VT[W-1], VT}) - $signed((W+1)'(VH));
  localparam logic [CW-1:0]     DEB_C = CW'(DEB);

  state_t          state, state_n;
  logic [CW-1:0]   cnt_n;
  logic [CW-1:0]   cnt_inc;
  logic            ready_q;
  logic            accept;
  logic            on_n;
  logic signed [W:0] vd;
  logic            above_hi;
  logic            below_lo;

  assign vc.vc_ready = ready_q;
  assign accept      = vc.vc_valid & ready_q;
  assign vd          = $signed({vc.vc_data[W-1], vc.vc_data});
  assign above_hi    = vd > HI;
  assign below_lo    = vd < LO;
  assign cnt_inc     = deb_cnt + 1'b1;

  always_comb begin
    state_n = state;
    cnt_n   = deb_cnt;
    if (!en) begin
      state_n = S_OFF;
      cnt_n   = '0;
    end else if (accept) begin
      case (state)
        S_OFF: begin
          if (above_hi) begin
            if (DEB == 1) begin
              state_n = S_ON;
              cnt_n   = '0;
            end else begin
              state_n = S_ARM_ON;
              cnt_n   = CW'(1);
            end
          end
        end
        S_ARM_ON: begin
          if (!above_hi) begin
            state_n = S_OFF;
            cnt_n   = '0;
          end else if (cnt_inc == DEB_C) begin
            state_n = S_ON;
            cnt_n   = '0;
          end else begin
            cnt_n   = cnt_inc;
          end
        end
        S_ON: begin
          if (below_lo) begin
            if (DEB == 1) begin
              state_n = S_OFF;
              cnt_n   = '0;
            end else begin
              state_n = S_ARM_OFF;
              cnt_n   = CW'(1);
            end
          end
        end
        S_ARM_OFF: begin
          if (!below_lo) begin
            state_n = S_ON;
            cnt_n   = '0;
          end else if (cnt_inc == DEB_C) begin
            state_n = S_OFF;
            cnt_n   = '0;
          end else begin
            cnt_n   = cnt_inc;
          end
        end
        default: begin
          state_n = S_OFF;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // The switch stays closed while arming to open, and open while arming to close.
  assign on_n = (state_n == S_ON) || (state_n == S_ARM_OFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_OFF;
      deb_cnt   <= '0;
      sw_on     <= 1'b0;
      sw_toggle <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state     <= state_n;
      deb_cnt   <= cnt_n;
      sw_on     <= on_n;
      sw_toggle <= on_n ^ sw_on;
      ready_q   <= 1'b1;
    end
  end

endmodule
